// File: rtl/alu_operand_issuer.sv
// Operand issuer for the registered ALU/shifter units: launches one operation at a time,
// waits RESULT_LATENCY cycles, then holds the captured result under a valid/ready handshake.
module alu_operand_issuer #(
    parameter int RESULT_LATENCY = 1
) (
    input  logic        soc_clk,
    input  logic        reset_n,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [4:0]  issue_op,
    input  logic [31:0] issue_rs1,
    input  logic [31:0] issue_rs2,
    input  logic [4:0]  issue_rd,
    output logic        dat_ready,
    output logic [31:0] ALU_dat1,
    output logic [31:0] ALU_dat2,
    output logic [4:0]  Instruction_to_ALU,
    input  logic [31:0] ALU_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    localparam logic [3:0] LAT = 4'(RESULT_LATENCY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic [4:0]  rd_p0;
    logic        accept;
    logic        capture;

    // A retire in HOLD frees the operand registers, so a new op can be taken at the same edge.
    assign issue_ready = (state == IDLE) || ((state == HOLD) && wb_ready);
    assign accept      = issue_valid && issue_ready;
    // Treating a zero count like one keeps an out-of-range latency from locking up in WAIT.
    assign capture     = (state == WAIT) && (wait_cnt <= 4'd1);

    always_ff @(posedge soc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dat_ready = 1'b0;
        wb_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                dat_ready = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (capture) state_nxt = HOLD;
            end
            HOLD: begin
                wb_valid = 1'b1;
                if (wb_ready) state_nxt = accept ? LAUNCH : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge soc_clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 4'd0;
        end else if (state == LAUNCH) begin
            wait_cnt <= LAT;
        end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Operands only move on accept so the ALU inputs stay frozen while a unit computes.
    always_ff @(posedge soc_clk or negedge reset_n) begin
        if (!reset_n) begin
            ALU_dat1           <= 32'h0;
            ALU_dat2           <= 32'h0;
            Instruction_to_ALU <= 5'h0;
            rd_p0              <= 5'h0;
            wb_data            <= 32'h0;
            wb_rd              <= 5'h0;
        end else begin
            if (accept) begin
                ALU_dat1           <= issue_rs1;
                ALU_dat2           <= issue_rs2;
                Instruction_to_ALU <= issue_op;
                rd_p0              <= issue_rd;
            end
            if (capture) begin
                wb_data <= ALU_result;
                wb_rd   <= rd_p0;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_issuer.sv
// Bench for alu_operand_issuer: latency-1 and latency-4 instances driven with directed and
// random operations, with ALU stubs and an arithmetic reference model for the results.
module tb_alu_operand_issuer;

    logic        soc_clk = 1'b0;
    logic        reset_n;

    logic        issue_valid, issue_ready, dat_ready, wb_valid, wb_ready;
    logic [4:0]  issue_op, issue_rd, instr, wb_rd;
    logic [31:0] issue_rs1, issue_rs2, alu_dat1, alu_dat2, alu_result, wb_data;

    logic        l4_issue_valid, l4_issue_ready, l4_dat_ready, l4_wb_valid, l4_wb_ready;
    logic [4:0]  l4_issue_op, l4_issue_rd, l4_instr, l4_wb_rd;
    logic [31:0] l4_issue_rs1, l4_issue_rs2, l4_alu_dat1, l4_alu_dat2, l4_alu_result, l4_wb_data;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [4:0]  opsel [4] = '{5'd8, 5'd12, 5'd13, 5'd3};
    logic [4:0]  s_op  [8];
    logic [4:0]  s_rd  [8];
    logic [31:0] s_rs1 [8];
    logic [31:0] s_rs2 [8];
    int          cyc, acc, ret, pulses, last_acc, n, seen;
    logic        adv;
    logic [31:0] x_rs1, x_rs2, y_rs1, y_rs2, tmp;
    int          l4_cd = 0;
    logic [31:0] l4_val;

    always #5 soc_clk = ~soc_clk;

    alu_operand_issuer #(.RESULT_LATENCY(1)) dut (
        .soc_clk(soc_clk), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .dat_ready(dat_ready), .ALU_dat1(alu_dat1), .ALU_dat2(alu_dat2),
        .Instruction_to_ALU(instr), .ALU_result(alu_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    alu_operand_issuer #(.RESULT_LATENCY(4)) dut4 (
        .soc_clk(soc_clk), .reset_n(reset_n),
        .issue_valid(l4_issue_valid), .issue_ready(l4_issue_ready),
        .issue_op(l4_issue_op), .issue_rs1(l4_issue_rs1), .issue_rs2(l4_issue_rs2),
        .issue_rd(l4_issue_rd),
        .dat_ready(l4_dat_ready), .ALU_dat1(l4_alu_dat1), .ALU_dat2(l4_alu_dat2),
        .Instruction_to_ALU(l4_instr), .ALU_result(l4_alu_result),
        .wb_valid(l4_wb_valid), .wb_ready(l4_wb_ready), .wb_rd(l4_wb_rd), .wb_data(l4_wb_data)
    );

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            5'd8:    return a << b[4:0];
            5'd12:   return a >> b[4:0];
            5'd13:   return $unsigned($signed(a) >>> b[4:0]);
            default: return a ^ b;
        endcase
    endfunction

    // Registered unit: result valid the cycle after launch, noise otherwise.
    always @(posedge soc_clk)
        alu_result <= dat_ready ? ref_alu(instr, alu_dat1, alu_dat2) : $urandom;

    // Slow unit: result present only in cycle launch+4.
    always @(posedge soc_clk) begin
        if (l4_dat_ready) begin
            l4_cd         <= 3;
            l4_val        <= ref_alu(l4_instr, l4_alu_dat1, l4_alu_dat2);
            l4_alu_result <= $urandom;
        end else if (l4_cd == 1) begin
            l4_alu_result <= l4_val;
            l4_cd         <= 0;
        end else begin
            if (l4_cd > 0) l4_cd <= l4_cd - 1;
            l4_alu_result <= $urandom;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: got %h expected %h", tag, obs, expv);
    endtask

    task automatic tick();
        @(negedge soc_clk);
    endtask

    task automatic do_op(input logic [4:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic [31:0] expv);
        issue_op = op; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd; issue_valid = 1'b1;
        #1 chk("idle_ready", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0;
        chk("launch_strobe", 32'(dat_ready), 32'd1);
        chk("launch_dat1", alu_dat1, rs1);
        chk("launch_dat2", alu_dat2, rs2);
        chk("launch_op", 32'(instr), 32'(op));
        chk("launch_busy", 32'(issue_ready), 32'd0);
        tick();
        chk("strobe_single", 32'(dat_ready), 32'd0);
        chk("wait_novalid", 32'(wb_valid), 32'd0);
        tick();
        chk("wb_valid_lat", 32'(wb_valid), 32'd1);
        chk("wb_data", wb_data, expv);
        chk("wb_rd", 32'(wb_rd), 32'(rd));
        tick();
        chk("retired", 32'(wb_valid), 32'd0);
        chk("idle_again", 32'(issue_ready), 32'd1);
        chk("dat1_held", alu_dat1, rs1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        issue_valid = 1'b0; issue_op = '0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
        wb_ready = 1'b1;
        l4_issue_valid = 1'b0; l4_issue_op = '0; l4_issue_rs1 = '0; l4_issue_rs2 = '0;
        l4_issue_rd = '0; l4_wb_ready = 1'b1;
        repeat (2) tick();
        chk("rst_strobe", 32'(dat_ready), 32'd0);
        chk("rst_valid", 32'(wb_valid), 32'd0);
        chk("rst_dat1", alu_dat1, 32'h0);
        chk("rst_dat2", alu_dat2, 32'h0);
        chk("rst_op", 32'(instr), 32'h0);
        chk("rst_wbdata", wb_data, 32'h0);
        chk("rst_wbrd", 32'(wb_rd), 32'h0);
        reset_n = 1'b1;
        tick();
        chk("rst_release_ready", 32'(issue_ready), 32'd1);

        // Directed shifts with hand-computed results
        do_op(5'd8, 32'h0000_0001, 32'd4, 5'd5, 32'h0000_0010);
        do_op(5'd13, 32'h8000_0000, 32'd31, 5'd7, 32'hFFFF_FFFF);
        do_op(5'd12, 32'h8000_0000, 32'd31, 5'd9, 32'h0000_0001);
        for (int i = 0; i < 3; i++) begin
            x_rs1 = $urandom; x_rs2 = $urandom; tmp = $urandom;
            do_op(tmp[4:0], x_rs1, x_rs2, tmp[9:5], ref_alu(tmp[4:0], x_rs1, x_rs2));
        end

        // Backpressure with a second op waiting
        wb_ready = 1'b0;
        x_rs1 = $urandom; x_rs2 = $urandom; y_rs1 = $urandom; y_rs2 = $urandom;
        issue_op = 5'd8; issue_rs1 = x_rs1; issue_rs2 = x_rs2; issue_rd = 5'd3;
        issue_valid = 1'b1;
        tick();
        issue_op = 5'd13; issue_rs1 = y_rs1; issue_rs2 = y_rs2; issue_rd = 5'd11;
        chk("bp_launch_dat1", alu_dat1, x_rs1);
        n = 0;
        while (!wb_valid && n < 10) begin tick(); n++; end
        chk("bp_valid_seen", 32'(wb_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid_hold", 32'(wb_valid), 32'd1);
            chk("bp_data_hold", wb_data, ref_alu(5'd8, x_rs1, x_rs2));
            chk("bp_not_ready", 32'(issue_ready), 32'd0);
            chk("bp_dat1_hold", alu_dat1, x_rs1);
            tick();
        end
        wb_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0;
        chk("bp_relaunch", 32'(dat_ready), 32'd1);
        chk("bp_retired", 32'(wb_valid), 32'd0);
        chk("bp_new_dat1", alu_dat1, y_rs1);
        chk("bp_new_op", 32'(instr), 32'd13);
        tick();
        tick();
        chk("bp_y_valid", 32'(wb_valid), 32'd1);
        chk("bp_y_data", wb_data, ref_alu(5'd13, y_rs1, y_rs2));
        chk("bp_y_rd", 32'(wb_rd), 32'd11);
        tick();

        // Latency-4 instance
        for (int i = 0; i < 2; i++) begin
            x_rs1 = $urandom; x_rs2 = $urandom;
            l4_issue_op = opsel[i + 1]; l4_issue_rs1 = x_rs1; l4_issue_rs2 = x_rs2;
            l4_issue_rd = 5'(i + 20); l4_issue_valid = 1'b1;
            tick();
            l4_issue_valid = 1'b0;
            n = 1;
            while (!l4_wb_valid && n < 20) begin tick(); n++; end
            chk("l4_latency", 32'(n), 32'd6);
            chk("l4_data", l4_wb_data, ref_alu(opsel[i + 1], x_rs1, x_rs2));
            chk("l4_rd", 32'(l4_wb_rd), 32'(i + 20));
            tick();
        end

        // Back-to-back stream
        for (int i = 0; i < 8; i++) begin
            tmp = $urandom;
            s_op[i] = opsel[tmp[1:0]]; s_rd[i] = tmp[8:4];
            s_rs1[i] = $urandom; s_rs2[i] = $urandom;
        end
        cyc = 0; acc = 0; ret = 0; pulses = 0; last_acc = -1;
        issue_op = s_op[0]; issue_rs1 = s_rs1[0]; issue_rs2 = s_rs2[0]; issue_rd = s_rd[0];
        issue_valid = 1'b1;
        while (ret < 8 && cyc < 100) begin
            adv = 1'b0;
            if (dat_ready) pulses++;
            if (wb_valid && exp_q.size() > 0) begin
                chk("stream_rd", 32'(wb_rd), 32'(exp_q[0].rd));
                chk("stream_data", wb_data, exp_q[0].data);
                void'(exp_q.pop_front());
                ret++;
            end
            if (issue_valid && issue_ready) begin
                if (last_acc >= 0) chk("stream_gap", 32'(cyc - last_acc), 32'd3);
                last_acc = cyc;
                exp_q.push_back('{s_rd[acc], ref_alu(s_op[acc], s_rs1[acc], s_rs2[acc])});
                acc++;
                adv = 1'b1;
            end
            tick();
            cyc++;
            if (adv) begin
                if (acc < 8) begin
                    issue_op = s_op[acc]; issue_rs1 = s_rs1[acc];
                    issue_rs2 = s_rs2[acc]; issue_rd = s_rd[acc];
                end else begin
                    issue_valid = 1'b0;
                end
            end
        end
        chk("stream_retired", 32'(ret), 32'd8);
        chk("stream_pulses", 32'(pulses), 32'd8);
        tick();

        // Reset in the middle of operations
        wb_ready = 1'b0; l4_wb_ready = 1'b0;
        issue_op = 5'd8; issue_rs1 = 32'h1234_5678; issue_rs2 = 32'd3; issue_rd = 5'd2;
        l4_issue_op = 5'd12; l4_issue_rs1 = 32'hCAFE_0000; l4_issue_rs2 = 32'd8;
        l4_issue_rd = 5'd4;
        issue_valid = 1'b1; l4_issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0; l4_issue_valid = 1'b0;
        tick();
        tick();
        chk("mid_hold_valid", 32'(wb_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(wb_valid), 32'd0);
        chk("mid_rst_wbdata", wb_data, 32'h0);
        chk("mid_rst_dat1", alu_dat1, 32'h0);
        chk("mid_rst_l4_strobe", 32'(l4_dat_ready), 32'd0);
        chk("mid_rst_l4_valid", 32'(l4_wb_valid), 32'd0);
        chk("mid_rst_l4_dat1", l4_alu_dat1, 32'h0);
        chk("mid_rst_l4_op", 32'(l4_instr), 32'h0);
        tick();
        reset_n = 1'b1; wb_ready = 1'b1; l4_wb_ready = 1'b1;
        tick();
        chk("post_rst_ready", 32'(issue_ready), 32'd1);
        chk("post_rst_l4_ready", 32'(l4_issue_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (wb_valid || l4_wb_valid || dat_ready || l4_dat_ready) seen++;
            tick();
        end
        chk("post_rst_quiet", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_issuer.md
# alu_operand_issuer

Sequencer that drives the ALU operand interface: it accepts one decoded ALU operation at a time from the decode stage, presents operands and opcode to the registered ALU units with a one-cycle `dat_ready` strobe, and waits a fixed result latency. It then captures the unit's output and holds it for writeback under a valid/ready handshake. It sits between decode and the ALU/Shifter datapath and guarantees that ALU inputs never change while a unit is computing.

## Interface
- `RESULT_LATENCY`, default 1: cycles from the `dat_ready` cycle to the first cycle `ALU_result` is valid. Legal range 1..15. Registered shifter = 1.
- `soc_clk`  in  1  system clock; all state on rising edge.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `issue_valid`  in  1  decode has an operation.
- `issue_ready`  out  1  issuer accepts this cycle.
- `issue_op`  in  5  ALU opcode (8 = SLL, 12 = SRL, 13 = SRA; others pass through verbatim).
- `issue_rs1`  in  32  operand 1.
- `issue_rs2`  in  32  operand 2 (shift amount in [4:0] for shifts).
- `issue_rd`  in  5  destination register tag.
- `dat_ready`  out  1  ALU launch strobe.
- `ALU_dat1`  out  32  registered operand 1.
- `ALU_dat2`  out  32  registered operand 2.
- `Instruction_to_ALU`  out  5  registered opcode.
- `ALU_result`  in  32  result from the selected ALU unit.
- `wb_valid`  out  1  result available.
- `wb_ready`  in  1  writeback accepts.
- `wb_rd`  out  5  destination tag of held result.
- `wb_data`  out  32  held result.

## Operation
- States: IDLE, LAUNCH, WAIT, HOLD. Reset → IDLE.
- `issue_ready` = (state == IDLE) or (state == HOLD and `wb_ready`).
- Accept on `issue_valid && issue_ready`. Latch `issue_op/rs1/rs2/rd` into `Instruction_to_ALU`, `ALU_dat1`, `ALU_dat2`, and an internal rd register. Next state is LAUNCH.
- LAUNCH: `dat_ready` = 1 for exactly this cycle. Load the wait counter with `RESULT_LATENCY`. Next state is WAIT.
- WAIT: the counter decrements each cycle. In the cycle the counter reads 1, sample `ALU_result` into `wb_data` and the rd register into `wb_rd`, and set `wb_valid`. Next state is HOLD.
- HOLD: `wb_valid` = 1. `wb_data` and `wb_rd` are stable until the cycle with `wb_ready` = 1.
  - `wb_ready` and no accept: clear `wb_valid`, go to IDLE.
  - `wb_ready` and accept in the same cycle: retire the current result and launch the new operation (go to LAUNCH). No bubble on the retire side.
- `ALU_dat1`, `ALU_dat2` and `Instruction_to_ALU` change only on an accept edge. They hold their value from LAUNCH through HOLD and through IDLE afterwards.
- `issue_rd` = 0 is not special-cased; writeback discards it.
- Opcode and operands are not interpreted; no arithmetic is done in this block.

## Timing
- Reset (`reset_n` low, asynchronous): state IDLE; `dat_ready`, `wb_valid` = 0; `ALU_dat1`, `ALU_dat2`, `wb_data` = 32'h0; `Instruction_to_ALU`, `wb_rd` = 5'h0; counter = 0. `issue_ready` = 1 in the first cycle after release.
- Reset mid-operation (any state) drops `dat_ready` and `wb_valid` immediately and discards the in-flight operation. No partial writeback.
- Accept at the edge ending cycle A gives:
  - `dat_ready` high in cycle A+1.
  - `ALU_result` sampled at the edge ending cycle A+1+`RESULT_LATENCY`.
  - `wb_valid` high from cycle A+2+`RESULT_LATENCY`.
  - Default latency: 3 cycles from accept edge to `wb_valid`.
- Throughput with `wb_ready` tied high is one operation per `RESULT_LATENCY`+2 cycles.
- `issue_ready` is low in LAUNCH and WAIT. `issue_*` inputs are ignored there regardless of `issue_valid`.
- `wb_valid` never deasserts without `wb_ready`. `wb_data` never changes while `wb_valid` = 1 and `wb_ready` = 0.

## Test plan
- Reset: drive `reset_n` low mid-WAIT → `dat_ready` = 0 and `wb_valid` = 0 asynchronously, all outputs 0. After release, `issue_ready` = 1 and no writeback appears.
- SLL: issue op 8, rs1 = 32'h0000_0001, rs2 = 32'd4, rd = 5, shifter attached, `wb_ready` = 1 → `dat_ready` is a single pulse one cycle after accept. `wb_valid` appears 3 cycles after accept with `wb_data` = 32'h0000_0010, `wb_rd` = 5.
- SRA: op 13, rs1 = 32'h8000_0000, rs2 = 32'd31 → `wb_data` = 32'hFFFF_FFFF. Then SRL, op 12, same operands → `wb_data` = 32'h0000_0001.
- Backpressure: hold `wb_ready` = 0 for 10 cycles with `issue_valid` = 1 →
  - `wb_valid` and `wb_data` stay stable, `issue_ready` = 0, `ALU_dat1` unchanged.
  - Raising `wb_ready` retires the result and accepts the next operation at the same edge; `dat_ready` pulses on the following cycle.
- Latency parameter: `RESULT_LATENCY` = 4, with a model that presents the result only in cycle launch+4 → the correct value is captured and `wb_valid` appears 6 cycles after accept.
- Stream: 8 back-to-back operations, `wb_ready` = 1 → exactly 8 `dat_ready` pulses, 8 retirements in order with matching `wb_rd`, and 3-cycle spacing between accepts.
